mem_wb_stage: RTL
=================

Name: mem_wb_stage

Overview:
- MEM/WB pipeline register plus write-back stage of the 5-stage MIPS pipeline; sits directly downstream of the memory stage.
- Captures ALU result, destination register and control from EX/MEM, and selects the register-file write data (ALU result, load data or link address).
- Drives the register-file write port and counts retired instructions.
- Implements the debug-unit run/step/halt control, which freezes write-back on a HALT instruction.

Parameters:
- NB_WIDTH, 32, data/address width.
- NB_REG, 5, register-file address width.
- NB_CNT, 32, retired-instruction counter width.

Ports:
- i_clk input 1 system clock, rising edge.
- i_reset input 1 asynchronous, active-low reset.
- i_valid input 1 instruction in MEM is valid (0 = bubble).
- i_alu_result input NB_WIDTH ALU result carried through MEM.
- i_mem_read_data input NB_WIDTH load data from MEM; already registered by MEM, valid in the cycle after capture.
- i_pc_plus8 input NB_WIDTH link address for JAL/JALR.
- i_rd_addr input NB_REG destination register.
- i_reg_write_CU input 1 register write enable.
- i_mem_to_reg_CU input 1 select load data.
- i_link_CU input 1 select link address.
- i_halt_CU input 1 instruction is HALT.
- i_step_mode input 1 debug unit requests step mode.
- i_step_req input 1 single-cycle pulse: advance one instruction.
- o_wb_data output NB_WIDTH register-file write data.
- o_wb_addr output NB_REG register-file write address.
- o_wb_we output 1 register-file write enable.
- o_halted output 1 HALT retired; pipeline frozen.
- o_step_done output 1 one-cycle pulse after a step completes.
- o_retired_cnt output NB_CNT retired-instruction count.

Behaviour:
- Reset (i_reset=0, asynchronous):
  - All pipeline registers, the fire flag and the counter clear to 0; state = RUN.
  - Outputs: o_wb_data=0, o_wb_addr=0, o_wb_we=0, o_halted=0, o_step_done=0, o_retired_cnt=0.
  - Deassertion is sampled synchronously; reset mid-step or while HALTED returns to RUN.
- FSM states: RUN, STEP_IDLE, STEP, HALTED.
  - advance = (state==RUN && !i_step_mode) || state==STEP.
  - RUN: captured HALT (advance && i_valid && i_halt_CU) -> HALTED; else i_step_mode=1 -> STEP_IDLE.
    - HALT has priority over i_step_mode in the same cycle.
  - STEP_IDLE: no advance.
    - i_step_mode=0 -> RUN.
    - else i_step_req=1 -> STEP.
    - i_step_req ignored in all other states.
  - STEP: exactly one advance.
    - Captured HALT -> HALTED.
    - Else -> STEP_IDLE, with o_step_done=1 for the next cycle.
  - HALTED: sticky until reset. No advance, o_wb_we=0, counter frozen, o_halted=1.
- Capture on advance: register alu_result, pc_plus8, rd_addr, reg_write, mem_to_reg, link, valid. Registers hold when not advancing.
- Fire flag:
  - Set to (i_valid && i_reg_write_CU && !i_halt_CU && i_rd_addr!=0) on an advance edge.
  - Cleared on every non-advance edge.
- Write-back outputs:
  - o_wb_we = fire. Exactly one write pulse per retired instruction, and no rewrite while stalled.
  - o_wb_addr = registered rd_addr.
  - o_wb_data mux, combinational from registered selects, priority link > mem_to_reg > ALU:
    - link -> registered pc_plus8
    - mem_to_reg -> live i_mem_read_data
    - else -> registered alu_result
  - The load path has one-cycle total latency from the MEM address edge, matching MEM's registered read.
- Counter: on advance with i_valid=1 and i_halt_CU=0, o_retired_cnt += 1, wrapping modulo 2^NB_CNT. Bubbles and HALT are not counted.
- Writes to $0 are suppressed (o_wb_we=0) but counted as retired.

Test Plan:
- Reset, then ADD $3 (i_alu_result=0x0000_0015, rd=3, reg_write=1, valid=1) for one cycle -> next cycle o_wb_we=1, o_wb_addr=3, o_wb_data=0x15, o_retired_cnt=1; following cycle (bubble) o_wb_we=0.
- LW rd=5 with mem_to_reg=1; MEM drives i_mem_read_data=0xDEAD_BEEF in the following cycle -> o_wb_data=0xDEADBEEF and o_wb_we=1 in that cycle.
- JAL: link=1, rd=31, pc_plus8=0x0000_0108, alu_result=0x55, mem_to_reg=1 -> o_wb_data=0x108, o_wb_addr=31.
- Step mode:
  - i_step_mode=1 with a valid instruction stream held -> no o_wb_we, counter static for 10 cycles.
  - Pulse i_step_req -> exactly one write, counter +1, o_step_done high for exactly one cycle.
  - i_step_mode=0 -> free run resumes.
- HALT with valid=1, followed by ADD rd=4 -> o_halted=1 from the next cycle, counter excludes HALT, no write for rd=4.
  - Then i_reset=0 mid-cycle -> all outputs 0 immediately, without waiting for a clock edge.
- Counter preloaded via 2^NB_CNT-1 retirements (NB_CNT=4 override: 15 instructions, then 1 more) -> o_retired_cnt wraps to 0. Instruction with rd=0, reg_write=1 -> o_wb_we=0, counter +1.

Source files
------------

// File: rtl/mem_wb_stage.sv
// MEM/WB pipeline register and write-back stage. It also holds the debug run/step/halt
// controller, which gates the pipeline advance and counts retired instructions.
module mem_wb_stage #(
  parameter int NB_WIDTH = 32,
  parameter int NB_REG   = 5,
  parameter int NB_CNT   = 32
) (
  input  logic                i_clk,
  input  logic                i_reset,
  input  logic                i_valid,
  input  logic [NB_WIDTH-1:0] i_alu_result,
  input  logic [NB_WIDTH-1:0] i_mem_read_data,
  input  logic [NB_WIDTH-1:0] i_pc_plus8,
  input  logic [NB_REG-1:0]   i_rd_addr,
  input  logic                i_reg_write_CU,
  input  logic                i_mem_to_reg_CU,
  input  logic                i_link_CU,
  input  logic                i_halt_CU,
  input  logic                i_step_mode,
  input  logic                i_step_req,
  output logic [NB_WIDTH-1:0] o_wb_data,
  output logic [NB_REG-1:0]   o_wb_addr,
  output logic                o_wb_we,
  output logic                o_halted,
  output logic                o_step_done,
  output logic [NB_CNT-1:0]   o_retired_cnt
);

  typedef enum logic [1:0] {RUN, STEP_IDLE, STEP, HALTED} state_t;

  state_t               state, state_nxt;
  logic                 advance;
  logic                 halt_cap;

  logic [NB_WIDTH-1:0]  alu_p1;
  logic [NB_WIDTH-1:0]  pc8_p1;
  logic [NB_REG-1:0]    rd_p1;
  logic                 rw_p1;
  logic                 m2r_p1;
  logic                 link_p1;
  logic                 vld_p1;
  logic                 fire_p1;
  logic                 step_done_p1;
  logic [NB_CNT-1:0]    cnt_p1;

  // Link address wins over load data, which wins over the ALU result.
  function automatic logic [NB_WIDTH-1:0] select_wb(
    input logic                link,
    input logic                m2r,
    input logic [NB_WIDTH-1:0] pc8,
    input logic [NB_WIDTH-1:0] mem,
    input logic [NB_WIDTH-1:0] alu
  );
    if (link)     return pc8;
    else if (m2r) return mem;
    else          return alu;
  endfunction

  assign advance  = ((state == RUN) && !i_step_mode) || (state == STEP);
  assign halt_cap = advance && i_valid && i_halt_CU;

  always_comb begin
    state_nxt = state;
    case (state)
      RUN: begin
        if (halt_cap)         state_nxt = HALTED;
        else if (i_step_mode) state_nxt = STEP_IDLE;
      end
      STEP_IDLE: begin
        if (!i_step_mode)     state_nxt = RUN;
        else if (i_step_req)  state_nxt = STEP;
      end
      STEP: begin
        if (halt_cap)         state_nxt = HALTED;
        else                  state_nxt = STEP_IDLE;
      end
      HALTED:                 state_nxt = HALTED;
      default:                state_nxt = RUN;
    endcase
  end

  // MEM -> WB boundary: capture only on advance; fire is a one-shot per advance.
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      state        <= RUN;
      alu_p1       <= '0;
      pc8_p1       <= '0;
      rd_p1        <= '0;
      rw_p1        <= 1'b0;
      m2r_p1       <= 1'b0;
      link_p1      <= 1'b0;
      vld_p1       <= 1'b0;
      fire_p1      <= 1'b0;
      step_done_p1 <= 1'b0;
      cnt_p1       <= '0;
    end else begin
      state        <= state_nxt;
      step_done_p1 <= (state == STEP) && !halt_cap;
      if (advance) begin
        alu_p1  <= i_alu_result;
        pc8_p1  <= i_pc_plus8;
        rd_p1   <= i_rd_addr;
        rw_p1   <= i_reg_write_CU;
        m2r_p1  <= i_mem_to_reg_CU;
        link_p1 <= i_link_CU;
        vld_p1  <= i_valid;
        fire_p1 <= i_valid && i_reg_write_CU && !i_halt_CU && (i_rd_addr != '0);
      end else begin
        fire_p1 <= 1'b0;
      end
      if (advance && i_valid && !i_halt_CU)
        cnt_p1 <= cnt_p1 + NB_CNT'(1);
    end
  end

  // Load data comes straight from MEM's registered read port, so it is not re-registered here.
  assign o_wb_data     = select_wb(link_p1, m2r_p1, pc8_p1, i_mem_read_data, alu_p1);
  assign o_wb_addr     = rd_p1;
  assign o_wb_we       = fire_p1 && vld_p1 && rw_p1 && (state != HALTED);
  assign o_halted      = (state == HALTED);
  assign o_step_done   = step_done_p1;
  assign o_retired_cnt = cnt_p1;

endmodule
